// File: rtl/ov7670_frame_writer.sv
// rtl/ov7670_frame_writer.sv - OV7670 RGB565 stream to SDRAM Avalon-MM single-beat write master
//
// Purpose: buffers camera pixels in a small FIFO tagged with their frame index and
// writes each one to BASE_ADDR + 2*index, so every frame lands linearly in memory.
//
// Ports:
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   enable                          level, capture frames continuously while 1
//   pix_valid, pix_sof, pix_data    pixel stream (sof marks pixel 0 of a frame)
//   avm_address/write/writedata     Avalon-MM write request (registered output stage)
//   avm_byteenable, avm_burstcount  constant 2'b11 / 1
//   avm_waitrequest                 slave stall
//   busy                            frame in progress (capturing or draining)
//   frame_done                      1-cycle pulse once the final write of a frame is accepted
//   frame_count                     completed frames, wraps
//   overflow                        sticky, a pixel was dropped on a full FIFO

module ov7670_frame_writer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [15:0] pix_data,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  output logic [1:0]  avm_byteenable,
  output logic        avm_burstcount,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        overflow
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [18:0] LAST_IDX = 19'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    DRAIN
  } state_t;

  state_t      state, next_state;
  logic [18:0] pcnt, pcnt_next;
  logic [18:0] push_idx;
  logic        push_req;

  // FIFO storage: {pixel index, pixel}
  logic [34:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [34:0] rd_data;
  logic        fifo_empty, fifo_full;
  logic        push, pop, drop;

  assign avm_byteenable = 2'b11;
  assign avm_burstcount = 1'b1;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data    = mem[rd_ptr[AW-1:0]];

  // The output stage takes a new entry when it is empty or its current write
  // completes this cycle, giving one write per clock with no bubbles.
  assign pop  = !fifo_empty && (!avm_write || !avm_waitrequest);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push = push_req && (!fifo_full || pop);
  assign drop = push_req && fifo_full && !pop;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
      pcnt  <= '0;
    end else begin
      state <= next_state;
      pcnt  <= pcnt_next;
    end
  end

  always_comb begin
    next_state = state;
    pcnt_next  = pcnt;
    push_req   = 1'b0;
    push_idx   = pcnt;
    frame_done = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) next_state = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (pix_valid && pix_sof) begin
          push_req   = 1'b1;
          push_idx   = '0;
          pcnt_next  = 19'd1;
          next_state = (LAST_IDX == 19'd0) ? DRAIN : CAPTURE;
        end
      end
      CAPTURE: begin
        busy = 1'b1;
        if (pix_valid) begin
          push_req  = 1'b1;
          // sof mid-frame restarts indexing; queued entries are still written
          push_idx  = pix_sof ? 19'd0 : pcnt;
          pcnt_next = push_idx + 19'd1;
          // pcnt advances even if this pixel gets dropped, keeping later addresses right
          if (push_idx == LAST_IDX) next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (fifo_empty && !avm_write) begin
          frame_done = 1'b1;
          next_state = enable ? WAIT_SOF : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {push_idx, pix_data};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered Avalon output stage; address/data hold while the slave stalls.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else if (pop) begin
      avm_write     <= 1'b1;
      avm_address   <= BASE_ADDR + {12'd0, rd_data[34:16], 1'b0};
      avm_writedata <= rd_data[15:0];
    end else if (avm_write && !avm_waitrequest) begin
      avm_write     <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (frame_done) frame_count <= frame_count + 8'd1;
      if (drop)       overflow    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// tb/tb_ov7670_frame_writer.sv - scoreboard bench for ov7670_frame_writer
module tb_ov7670_frame_writer;

  localparam logic [31:0] BASE  = 32'hFFFF_FFE0;
  localparam int          HR    = 4;
  localparam int          VR    = 8;
  localparam int          NPIX  = HR * VR;
  localparam int          DEPTH = 16;

  logic        clk = 0;
  logic        rst_n;
  logic        enable;
  logic        pix_valid;
  logic        pix_sof;
  logic [15:0] pix_data;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_burstcount;
  logic        avm_waitrequest;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        overflow;

  ov7670_frame_writer #(
    .BASE_ADDR(BASE), .H_RES(HR), .V_RES(VR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  bit   armed, in_frame, draining, m_ovf;
  int   m_idx, accepted, completed, exp_frames, done_seen;
  int   wr_mode, stall_cnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock of stimulus; entered and left 1 time unit after a rising edge
  task automatic cycle(bit v, bit s, logic [15:0] d);
    int  idx;
    bit  dropped;
    case (wr_mode)
      0: avm_waitrequest = 1'b0;
      1: begin
        if (avm_write) begin
          if (stall_cnt >= 3) begin avm_waitrequest = 1'b0; stall_cnt = 0; end
          else begin avm_waitrequest = 1'b1; stall_cnt++; end
        end else avm_waitrequest = 1'($urandom_range(0, 1));
      end
      default: avm_waitrequest = 1'b1;
    endcase
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    if (v && !draining && (in_frame || (armed && s))) begin
      idx = s ? 0 : m_idx;
      in_frame = 1;
      armed = 0;
      // writer holds FIFO_DEPTH queued entries plus one in flight
      dropped = avm_waitrequest && ((accepted - completed) == DEPTH + 1);
      if (dropped) m_ovf = 1;
      else begin
        exp_q.push_back('{addr: BASE + 32'(idx) * 32'd2, data: d, last: (idx == NPIX - 1)});
        accepted++;
      end
      m_idx = idx + 1;
      if (idx == NPIX - 1) begin
        in_frame = 0;
        draining = 1;
        exp_frames++;
      end
    end
    if (!in_frame && !draining && enable) armed = 1;
    @(posedge clk);
    #1;
    pix_valid = 0;
    pix_sof   = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 600 && done_seen != exp_frames; i++) cycle(0, 0, 16'h0);
    chk("frame_done_count", done_seen, exp_frames);
    draining = 0;
    armed = enable;
  endtask

  task automatic send_frame(int first_idx, int n, bit sof_first);
    for (int i = 0; i < n; i++) cycle(1, sof_first && (i == 0), 16'($urandom));
  endtask

  task automatic model_reset();
    exp_q.delete();
    armed = 0; in_frame = 0; draining = 0; m_ovf = 0;
    m_idx = 0; accepted = 0; completed = 0; exp_frames = 0; done_seen = 0;
    stall_cnt = 0;
  endtask

  // monitor: pops the scoreboard on every accepted write
  logic [31:0] hold_addr;
  logic [15:0] hold_data;
  bit          prev_stall, done_pending;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 0;
      done_pending = 0;
    end else begin
      if (done_pending) begin
        chk("frame_done_after_last_write", frame_done, 1);
        done_pending = 0;
      end
      if (frame_done) done_seen++;
      if (prev_stall) begin
        chk("stall_write_held", avm_write, 1);
        chk("stall_addr_stable", avm_address, hold_addr);
        chk("stall_data_stable", avm_writedata, hold_data);
      end
      prev_stall = avm_write && avm_waitrequest;
      hold_addr  = avm_address;
      hold_data  = avm_writedata;
      if (avm_write && !avm_waitrequest) begin
        completed++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %h data %h, none expected", avm_address, avm_writedata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("write_addr", avm_address, e.addr);
          chk("write_data", 32'(avm_writedata), 32'(e.data));
          if (e.last) done_pending = 1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; enable = 0; pix_valid = 0; pix_sof = 0; pix_data = 0;
    avm_waitrequest = 0; wr_mode = 0;
    model_reset();
    #3;
    chk("rst_avm_write", avm_write, 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_avm_writedata", 32'(avm_writedata), 0);
    chk("rst_byteenable", 32'(avm_byteenable), 3);
    chk("rst_burstcount", 32'(avm_burstcount), 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // sof before enable is ignored
    cycle(1, 1, 16'hdead);
    cycle(0, 0, 0);
    chk("idle_no_queue", exp_q.size(), 0);

    // 1: linear frame, no stall, plus first-write latency
    enable = 1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    cycle(1, 1, 16'h1000);
    @(negedge clk); chk("latency_n1_write", avm_write, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("latency_n2_write", avm_write, 1);
    @(posedge clk); #1;
    for (int i = 1; i < NPIX; i++) cycle(1, 0, 16'(16'h1000 + i));
    wait_done();
    chk("t1_frame_count", 32'(frame_count), 32'(exp_frames));
    chk("t1_busy_after", busy, 0);

    // 2: slow slave, FIFO-sized bursts must not overflow
    wr_mode = 1; stall_cnt = 0;
    cycle(1, 1, 16'($urandom));
    for (int i = 1; i < DEPTH; i++) cycle(1, 0, 16'($urandom));
    for (int i = 0; i < 80; i++) cycle(0, 0, 0);
    for (int i = DEPTH; i < NPIX; i++) cycle(1, 0, 16'($urandom));
    wait_done();
    chk("t2_overflow", overflow, 0);
    chk("t2_model_no_drop", m_ovf, 0);

    // 3: stuck slave drops pixels, later pixels keep their addresses
    wr_mode = 2;
    cycle(1, 1, 16'($urandom));
    for (int i = 1; i < 24; i++) cycle(1, 0, 16'($urandom));
    chk("t3_queued", accepted - completed, DEPTH + 1);
    wr_mode = 0;
    for (int i = 24; i < NPIX; i++) cycle(1, 0, 16'($urandom));
    wait_done();
    chk("t3_overflow", overflow, 1);

    // 4: sof restarts at pixel 5, random gaps
    cycle(1, 1, 16'($urandom));
    for (int i = 1; i < 5; i++) cycle(1, 0, 16'($urandom));
    cycle(1, 1, 16'($urandom));
    for (int i = 1; i < NPIX; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(0, 0, 0);
      cycle(1, 0, 16'($urandom));
    end
    wait_done();
    chk("t4_frame_count", 32'(frame_count), 32'(exp_frames));

    // 5: enable dropped mid-frame, frame completes, then sof ignored
    cycle(1, 1, 16'($urandom));
    for (int i = 1; i < 10; i++) cycle(1, 0, 16'($urandom));
    enable = 0;
    for (int i = 10; i < NPIX; i++) cycle(1, 0, 16'($urandom));
    wait_done();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    chk("t5_busy_idle", busy, 0);
    cycle(1, 1, 16'hbeef);
    for (int i = 0; i < 6; i++) cycle(1, 0, 16'($urandom));
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    chk("t5_busy_ignored_sof", busy, 0);
    enable = 1;
    cycle(0, 0, 0); cycle(0, 0, 0);
    send_frame(0, NPIX, 1);
    wait_done();
    chk("t5_frame_count", 32'(frame_count), 32'(exp_frames));

    // 6: reset during a stalled write
    wr_mode = 2;
    cycle(1, 1, 16'($urandom));
    cycle(1, 0, 16'($urandom));
    cycle(1, 0, 16'($urandom));
    cycle(0, 0, 0); cycle(0, 0, 0);
    @(negedge clk); chk("t6_stalled_write", avm_write, 1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("t6_rst_write", avm_write, 0);
    chk("t6_rst_frame_count", 32'(frame_count), 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_busy", busy, 0);
    model_reset();
    wr_mode = 0;
    avm_waitrequest = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    chk("t6_no_resume", completed, 0);
    send_frame(0, NPIX, 1);
    wait_done();

    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_frame_count", 32'(frame_count), 32'(exp_frames));
    chk("end_overflow", overflow, m_ovf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
